// File: rtl/register_file_sb.sv
// Register file with a per-register pending (scoreboard) bit: claims mark a register as
// awaiting an in-flight producer, the producer's write clears it, flush drops all claims.
module register_file_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    output logic [NUM_RD-1:0]          rd_busy,
    input  logic                       wr_en,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic                       claim_en,
    input  logic [ADDR_W-1:0]          claim_addr,
    input  logic                       flush
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] r_data [DEPTH];
    logic [DEPTH-1:0]  r_pend;
    logic [DEPTH-1:0]  w_pend_next;
    logic              w_wr_ok;
    logic              w_claim_ok;

    // Register 0 is hard-wired when ZERO_REG is set, so it never stores data or a claim.
    assign w_wr_ok    = wr_en && !((ZERO_REG != 0) && (wr_addr == '0));
    assign w_claim_ok = claim_en && !flush && !((ZERO_REG != 0) && (claim_addr == '0));

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_data[i] <= '0;
            end
        end else if (w_wr_ok) begin
            r_data[wr_addr] <= wr_data;
        end
    end

    // Claim is applied after the write-clear so a same-address claim leaves the bit set.
    always_comb begin
        w_pend_next = r_pend;
        if (flush) begin
            w_pend_next = '0;
        end else if (wr_en) begin
            w_pend_next[wr_addr] = 1'b0;
        end
        if (w_claim_ok) begin
            w_pend_next[claim_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend <= '0;
        end else begin
            r_pend <= w_pend_next;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] w_addr;
        logic              w_zero;
        logic              w_fwd;

        assign w_addr = rd_addr[k*ADDR_W +: ADDR_W];
        assign w_zero = (ZERO_REG != 0) && (w_addr == '0);
        // Forwarding is disabled during reset so reads show stored state only.
        assign w_fwd  = (BYPASS != 0) && !rst && wr_en && (wr_addr == w_addr);

        assign rd_data[k*DATA_W +: DATA_W] = w_zero ? '0 : (w_fwd ? wr_data : r_data[w_addr]);
        assign rd_busy[k] = !w_zero && !w_fwd && r_pend[w_addr];
    end

endmodule

// File: tb/tb_register_file_sb.sv
// Bench for register_file_sb: directed scenarios plus a randomized run against an
// array-based model of the register values and outstanding claims.
module tb_register_file_sb;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int NR    = 2;
    localparam int DEPTH = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic [NR*AW-1:0] rd_addr;
    logic [NR*DW-1:0] rd_data;
    logic [NR-1:0]    rd_busy;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [DW-1:0]    wr_data;
    logic             claim_en;
    logic [AW-1:0]    claim_addr;
    logic             flush;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [DW-1:0] m_mem  [DEPTH];
    bit            m_pend [DEPTH];

    always #5 clk = ~clk;

    register_file_sb #(
        .DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1), .BYPASS(1)
    ) dut (
        .clk(clk), .rst(rst),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .claim_en(claim_en), .claim_addr(claim_addr), .flush(flush)
    );

    // Expected read: reg 0 is always zero, a live write is seen at once, else stored value.
    function automatic logic [DW-1:0] exp_data(input logic [AW-1:0] a);
        if (a == 0) return '0;
        if (!rst && wr_en && wr_addr == a) return wr_data;
        return m_mem[a];
    endfunction

    function automatic logic exp_busy(input logic [AW-1:0] a);
        if (a == 0) return 1'b0;
        if (!rst && wr_en && wr_addr == a) return 1'b0;
        return m_pend[a];
    endfunction

    function automatic void model_update();
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                m_mem[i]  = '0;
                m_pend[i] = 1'b0;
            end
        end else begin
            if (wr_en) begin
                if (wr_addr != 0) m_mem[wr_addr] = wr_data;
                m_pend[wr_addr] = 1'b0;
            end
            if (flush) begin
                for (int i = 0; i < DEPTH; i++) m_pend[i] = 1'b0;
            end else if (claim_en && claim_addr != 0) begin
                m_pend[claim_addr] = 1'b1;
            end
        end
    endfunction

    function automatic logic [DW-1:0] port_data(input int k);
        return rd_data[k*DW +: DW];
    endfunction

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic drive_idle();
        wr_en      = 1'b0;
        wr_addr    = '0;
        wr_data    = '0;
        claim_en   = 1'b0;
        claim_addr = '0;
        flush      = 1'b0;
    endtask

    task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        rd_addr[0*AW +: AW] = a0;
        rd_addr[1*AW +: AW] = a1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive_idle();
        set_rd(5'd0, 5'd0);
        tick();
        tick();
        rst = 1'b0;
        for (int a = 0; a < DEPTH; a++) begin
            set_rd(a[AW-1:0], 5'(DEPTH - 1 - a));
            #4;
            for (int k = 0; k < NR; k++) begin
                tests_run++;
                if (port_data(k) !== '0 || rd_busy[k] !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL reset_state port%0d addr%0d: got data=%h busy=%b, want 0/0",
                             k, rd_addr[k*AW +: AW], port_data(k), rd_busy[k]);
                end
            end
            tick();
        end
    endtask

    task automatic test_bypass();
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hDEADBEEF;
        set_rd(5'd3, 5'd1);
        #4;
        tests_run++;
        if (port_data(0) !== 32'hDEADBEEF) begin
            tests_failed++;
            $display("FAIL bypass_same_cycle: got %h want deadbeef", port_data(0));
        end
        tick();
        drive_idle();
        #4;
        tests_run++;
        if (port_data(0) !== 32'hDEADBEEF || rd_busy[0] !== 1'b0) begin
            tests_failed++;
            $display("FAIL bypass_stored: got %h busy=%b want deadbeef/0", port_data(0), rd_busy[0]);
        end
        tick();
    endtask

    task automatic test_claim_write();
        claim_en = 1'b1; claim_addr = 5'd7;
        tick();
        drive_idle();
        set_rd(5'd1, 5'd7);
        #4;
        tests_run++;
        if (rd_busy[1] !== 1'b1) begin
            tests_failed++;
            $display("FAIL claim_busy: got %b want 1", rd_busy[1]);
        end
        tick();
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h55;
        #4;
        tests_run++;
        if (rd_busy[1] !== 1'b0 || port_data(1) !== 32'h55) begin
            tests_failed++;
            $display("FAIL claim_write_fwd: got %h busy=%b want 00000055/0", port_data(1), rd_busy[1]);
        end
        tick();
        drive_idle();
        #4;
        tests_run++;
        if (rd_busy[1] !== 1'b0 || port_data(1) !== 32'h55) begin
            tests_failed++;
            $display("FAIL claim_write_after: got %h busy=%b want 00000055/0", port_data(1), rd_busy[1]);
        end
        tick();
    endtask

    task automatic test_claim_and_write_same();
        claim_en = 1'b1; claim_addr = 5'd9;
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h11;
        set_rd(5'd9, 5'd9);
        tick();
        drive_idle();
        #4;
        for (int k = 0; k < NR; k++) begin
            tests_run++;
            if (port_data(k) !== 32'h11 || rd_busy[k] !== 1'b1) begin
                tests_failed++;
                $display("FAIL claim_wins port%0d: got %h busy=%b want 00000011/1", k, port_data(k), rd_busy[k]);
            end
        end
        tick();
    endtask

    task automatic test_flush();
        for (int a = 4; a <= 6; a++) begin
            wr_en = 1'b1; wr_addr = a[AW-1:0]; wr_data = 32'hA000 + a;
            tick();
        end
        drive_idle();
        for (int a = 4; a <= 6; a++) begin
            claim_en = 1'b1; claim_addr = a[AW-1:0];
            tick();
        end
        drive_idle();
        set_rd(5'd4, 5'd6);
        #4;
        tests_run++;
        if (rd_busy !== 2'b11) begin
            tests_failed++;
            $display("FAIL flush_pre_busy: got %b want 11", rd_busy);
        end
        flush = 1'b1; claim_en = 1'b1; claim_addr = 5'd8;
        tick();
        drive_idle();
        for (int a = 4; a <= 8; a++) begin
            if (a == 7) continue;
            set_rd(a[AW-1:0], a[AW-1:0]);
            #4;
            tests_run++;
            if (rd_busy[0] !== 1'b0 || rd_busy[1] !== 1'b0) begin
                tests_failed++;
                $display("FAIL flush_busy addr%0d: got %b want 00", a, rd_busy);
            end
            if (a <= 6) begin
                tests_run++;
                if (port_data(0) !== 32'hA000 + a) begin
                    tests_failed++;
                    $display("FAIL flush_data addr%0d: got %h want %h", a, port_data(0), 32'hA000 + a);
                end
            end
            tick();
        end
    endtask

    task automatic test_zero_reg();
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF;
        claim_en = 1'b1; claim_addr = 5'd0;
        set_rd(5'd0, 5'd0);
        #4;
        tests_run++;
        if (rd_data !== '0 || rd_busy !== 2'b00) begin
            tests_failed++;
            $display("FAIL zero_reg_during: got %h busy=%b want 0/00", rd_data, rd_busy);
        end
        tick();
        drive_idle();
        #4;
        tests_run++;
        if (rd_data !== '0 || rd_busy !== 2'b00) begin
            tests_failed++;
            $display("FAIL zero_reg_after: got %h busy=%b want 0/00", rd_data, rd_busy);
        end
        tick();
    endtask

    task automatic test_reset_priority();
        wr_en = 1'b1; wr_addr = 5'd2; wr_data = 32'h1234;
        tick();
        drive_idle();
        claim_en = 1'b1; claim_addr = 5'd2;
        tick();
        drive_idle();
        rst = 1'b1; wr_en = 1'b1; wr_addr = 5'd2; wr_data = 32'hABCD;
        claim_en = 1'b1; claim_addr = 5'd2;
        set_rd(5'd2, 5'd2);
        #4;
        tests_run++;
        if (port_data(0) !== 32'h1234 || rd_busy[0] !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_no_fwd: got %h busy=%b want 00001234/1", port_data(0), rd_busy[0]);
        end
        tick();
        rst = 1'b0;
        drive_idle();
        #4;
        tests_run++;
        if (port_data(1) !== '0 || rd_busy[1] !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_priority: got %h busy=%b want 0/0", port_data(1), rd_busy[1]);
        end
        tick();
    endtask

    task automatic test_random();
        logic [AW-1:0] a [NR];
        for (int n = 0; n < 400; n++) begin
            rst        = ($urandom_range(0, 59) == 0);
            wr_en      = $urandom_range(0, 1);
            wr_addr    = AW'($urandom_range(0, 9));
            wr_data    = $urandom;
            claim_en   = $urandom_range(0, 1);
            claim_addr = AW'($urandom_range(0, 9));
            flush      = ($urandom_range(0, 11) == 0);
            for (int k = 0; k < NR; k++) begin
                a[k] = ($urandom_range(0, 3) == 0) ? wr_addr : AW'($urandom_range(0, 11));
            end
            set_rd(a[0], a[1]);
            #4;
            for (int k = 0; k < NR; k++) begin
                tests_run++;
                if (port_data(k) !== exp_data(a[k]) || rd_busy[k] !== exp_busy(a[k])) begin
                    tests_failed++;
                    $display("FAIL random cycle%0d port%0d addr%0d: got %h/%b want %h/%b",
                             n, k, a[k], port_data(k), rd_busy[k], exp_data(a[k]), exp_busy(a[k]));
                end
            end
            tick();
        end
        rst = 1'b0;
        drive_idle();
    endtask

    initial begin
        rst = 1'b1;
        rd_addr = '0;
        drive_idle();
        #1;
        test_reset();
        test_bypass();
        test_claim_write();
        test_claim_and_write_same();
        test_flush();
        test_zero_reg();
        test_reset_priority();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/register_file_sb.md
REGISTER_FILE_SB -- requirements
Module: register_file_sb

Interface
REQ-001 SHALL have parameter DATA_W, default 32: width of each register and data port.
REQ-002 SHALL have parameter ADDR_W, default 5: address width; depth = 2**ADDR_W.
REQ-003 SHALL have parameter NUM_RD, default 2: number of independent read ports.
REQ-004 SHALL have parameter ZERO_REG, default 1: 1 = register 0 reads 0 and ignores writes and claims.
REQ-005 SHALL have parameter BYPASS, default 1: 1 = same-cycle write-to-read forwarding.
REQ-006 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-007 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-008 SHALL have port rd_addr  input  NUM_RD*ADDR_W  read addresses; port k at bits [k*ADDR_W +: ADDR_W].
REQ-009 SHALL have port rd_data  output  NUM_RD*DATA_W  read data; port k at bits [k*DATA_W +: DATA_W].
REQ-010 SHALL have port rd_busy  output  NUM_RD  1 = addressed register has an outstanding producer.
REQ-011 SHALL have port wr_en  input  1  write strobe.
REQ-012 SHALL have port wr_addr  input  ADDR_W  write address.
REQ-013 SHALL have port wr_data  input  DATA_W  write data.
REQ-014 SHALL have port claim_en  input  1  marks claim_addr pending (in-flight producer issued).
REQ-015 SHALL have port claim_addr  input  ADDR_W  register being claimed.
REQ-016 SHALL have port flush  input  1  clears all pending bits; register data untouched.

Function
REQ-017 SHALL hold a 2**ADDR_W x DATA_W data array and a 2**ADDR_W x 1 pending array.
REQ-018 SHALL read combinationally: rd_data[k] = array[rd_addr[k]], zero latency.
REQ-019 SHALL, on a rising edge with wr_en=1, write wr_data to array[wr_addr] and clear pending[wr_addr].
REQ-020 SHALL, on a rising edge with claim_en=1, set pending[claim_addr].
REQ-021 SHALL, when claim and write target the same address in one cycle, store data and leave pending=1 (claim wins).
REQ-022 SHALL, when flush=1, clear every pending bit; flush overrides a same-cycle claim (no bit set); a same-cycle write still updates data.
REQ-023 SHALL, with BYPASS=1, drive rd_data[k]=wr_data when wr_en=1 and wr_addr==rd_addr[k] (combinational forward).
REQ-024 SHALL, with BYPASS=1, drive rd_busy[k]=0 when the forward of REQ-023 is active; otherwise rd_busy[k]=pending[rd_addr[k]].
REQ-025 SHALL, with BYPASS=0, drive rd_data/rd_busy from stored state only; a write is visible the cycle after.
REQ-026 SHALL, with ZERO_REG=1, return rd_data=0 and rd_busy=0 for address 0 regardless of writes, claims or forwarding.
REQ-027 SHALL serve all NUM_RD ports independently; identical addresses on several ports return identical values.
REQ-028 SHALL produce no X on outputs for any in-range address after the first reset.

Reset
REQ-029 SHALL, on a rising edge with rst=1, clear all data registers and all pending bits to 0.
REQ-030 SHALL give rst priority over wr_en, claim_en and flush in the same cycle (all ignored).
REQ-031 SHALL suppress forwarding while rst=1; rd_data and rd_busy reflect stored state only.
REQ-032 SHALL, after reset deasserts, read 0 and busy 0 on every port for every address.

Verification
REQ-033 Reset then wr_en=1, wr_addr=3, wr_data=0xDEADBEEF, rd_addr[0]=3 same cycle -> rd_data[0]=0xDEADBEEF that cycle (BYPASS=1); next cycle with wr_en=0 still 0xDEADBEEF.
REQ-034 claim_en=1, claim_addr=7; next cycle rd_addr[1]=7 -> rd_busy[1]=1; then wr_en=1, wr_addr=7, wr_data=0x55 -> same cycle rd_busy[1]=0, rd_data[1]=0x55; following cycle pending[7]=0.
REQ-035 Same cycle claim_addr=9 and wr_addr=9, wr_data=0x11 -> next cycle rd_data=0x11, rd_busy=1.
REQ-036 Claim regs 4,5,6 over three cycles, then flush=1 with claim_addr=8 -> next cycle busy=0 for 4,5,6,8; data of 4,5,6 unchanged.
REQ-037 ZERO_REG=1: wr_en=1, wr_addr=0, wr_data=0xFFFFFFFF and claim_addr=0 -> rd_data=0 and rd_busy=0 for address 0 during and after.
REQ-038 Write 0x1234 to reg 2, claim reg 2, then rst=1 with wr_en=1, wr_addr=2, wr_data=0xABCD -> after edge reg 2 reads 0, busy 0.
